// File: rtl/regfile_alu_pipe_if.sv
// Issue/result bus of regfile_alu_pipe.
// The master issues micro-ops and consumes retired results; the slave is the pipeline.
interface regfile_alu_pipe_if #(
    parameter int WIDTH = 32,
    parameter int NREGS = 32
);
    localparam int AW = $clog2(NREGS);

    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [AW-1:0]    in_rs1;
    logic [AW-1:0]    in_rs2;
    logic [AW-1:0]    in_rd;
    logic             in_we;
    logic             res_valid;
    logic [WIDTH-1:0] res_data;
    logic [AW-1:0]    res_rd;
    logic             res_zero;

    modport master (
        output in_valid, in_op, in_rs1, in_rs2, in_rd, in_we,
        input  in_ready, res_valid, res_data, res_rd, res_zero
    );

    modport slave (
        input  in_valid, in_op, in_rs1, in_rs2, in_rd, in_we,
        output in_ready, res_valid, res_data, res_rd, res_zero
    );
endinterface

// File: rtl/regfile_alu_pipe.sv
// Register file + ALU as a two-stage issue/execute pipeline.
// Stage X result is forwarded to the operands of the op being issued.
// Optional feature macro: ALU_MUL_EN -- op 011 becomes a WIDTH-cycle
// shift-add multiply; when undefined op 011 returns 0 in one cycle.
module regfile_alu_pipe #(
    parameter int WIDTH = 32,
    parameter int NREGS = 32,
    localparam int AW = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    regfile_alu_pipe_if.slave bus,
    input  logic             dbg_we,
    input  logic [AW-1:0]    dbg_addr,
    input  logic [WIDTH-1:0] dbg_wdata,
    input  logic [AW-1:0]    probe_addr,
    output logic [WIDTH-1:0] probe_data
);
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    // Stage X state
    logic             x_valid_q, x_valid_d;
    logic [2:0]       x_op_q,    x_op_d;
    logic [WIDTH-1:0] x_a_q,     x_a_d;
    logic [WIDTH-1:0] x_b_q,     x_b_d;
    logic [AW-1:0]    x_rd_q,    x_rd_d;
    logic             x_we_q,    x_we_d;

    // Retire registers
    logic             res_valid_q, res_valid_d;
    logic [WIDTH-1:0] res_data_q,  res_data_d;
    logic [AW-1:0]    res_rd_q,    res_rd_d;
    logic             res_zero_q,  res_zero_d;

    logic             x_done;
    logic [WIDTH-1:0] x_result;
    logic             x_slt;
    logic             accept;
    logic             wb_en;
    logic             fwd_a, fwd_b;
    logic [WIDTH-1:0] op_a, op_b;
    logic [WIDTH-1:0] rf [NREGS];

`ifdef ALU_MUL_EN
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    logic [CW-1:0]    mul_cnt_q, mul_cnt_d;
    logic [WIDTH-1:0] x_acc_q,   x_acc_d;
    logic [WIDTH-1:0] mul_step;

    // Partial product for the current multiplier bit (x_b_q shifts right, x_a_q left)
    assign mul_step = x_b_q[0] ? x_a_q : '0;
    // A multiply occupies stage X until its counter reaches the last bit
    assign x_done   = x_valid_q && ((x_op_q != OP_MUL) || (mul_cnt_q == CW'(WIDTH - 1)));
`else
    assign x_done   = x_valid_q;
`endif

    assign bus.in_ready = !x_valid_q || x_done;
    assign accept       = bus.in_valid && bus.in_ready;
    assign wb_en        = x_done && x_we_q && (x_rd_q != '0);

    // Register file: r0 is constant zero, others take pipeline writeback over debug writes
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign rf[gi] = '0;
            end else begin : g_flop
                logic [WIDTH-1:0] reg_q, reg_d;

                // Next value: pipeline result wins a same-edge conflict with a debug write
                always_comb begin
                    reg_d = reg_q;
                    if (dbg_we && (dbg_addr == AW'(gi))) begin
                        reg_d = dbg_wdata;
                    end
                    if (wb_en && (x_rd_q == AW'(gi))) begin
                        reg_d = x_result;
                    end
                end

                // Register storage with synchronous clear
                always_ff @(posedge clk) begin
                    if (rst) begin
                        reg_q <= '0;
                    end else begin
                        reg_q <= reg_d;
                    end
                end

                assign rf[gi] = reg_q;
            end
        end
    endgenerate

    assign probe_data = rf[probe_addr];

    // ALU result of the op held in stage X
    always_comb begin
        x_slt    = $signed(x_a_q) < $signed(x_b_q);
        x_result = '0;
        case (x_op_q)
            OP_AND:  x_result = x_a_q & x_b_q;
            OP_OR:   x_result = x_a_q | x_b_q;
            OP_ADD:  x_result = x_a_q + x_b_q;
            OP_SUB:  x_result = x_a_q - x_b_q;
            OP_SLT:  x_result = {{(WIDTH-1){1'b0}}, x_slt};
`ifdef ALU_MUL_EN
            OP_MUL:  x_result = x_acc_q + mul_step;
`endif
            default: x_result = '0;
        endcase
    end

    // Operand fetch with forwarding from a finishing stage-X op
    always_comb begin
        fwd_a = wb_en && (x_rd_q == bus.in_rs1);
        fwd_b = wb_en && (x_rd_q == bus.in_rs2);
        op_a  = fwd_a ? x_result : rf[bus.in_rs1];
        op_b  = fwd_b ? x_result : rf[bus.in_rs2];
    end

    // Stage X load / multiply iteration / retire bookkeeping
    always_comb begin
        x_valid_d   = x_valid_q;
        x_op_d      = x_op_q;
        x_a_d       = x_a_q;
        x_b_d       = x_b_q;
        x_rd_d      = x_rd_q;
        x_we_d      = x_we_q;
`ifdef ALU_MUL_EN
        mul_cnt_d   = mul_cnt_q;
        x_acc_d     = x_acc_q;
`endif
        res_valid_d = x_done;
        res_data_d  = res_data_q;
        res_rd_d    = res_rd_q;
        res_zero_d  = res_zero_q;

        if (x_done) begin
            res_data_d = x_result;
            res_rd_d   = x_rd_q;
            res_zero_d = (x_result == '0);
        end

        if (accept) begin
            x_valid_d = 1'b1;
            x_op_d    = bus.in_op;
            x_a_d     = op_a;
            x_b_d     = op_b;
            x_rd_d    = bus.in_rd;
            x_we_d    = bus.in_we;
`ifdef ALU_MUL_EN
            mul_cnt_d = '0;
            x_acc_d   = '0;
`endif
        end else if (x_done) begin
            x_valid_d = 1'b0;
`ifdef ALU_MUL_EN
        end else if (x_valid_q) begin
            // One multiplier bit per cycle
            x_acc_d   = x_acc_q + mul_step;
            x_a_d     = x_a_q << 1;
            x_b_d     = x_b_q >> 1;
            mul_cnt_d = mul_cnt_q + 1'b1;
`endif
        end
    end

    // Pipeline state registers; reset drops any in-flight op
    always_ff @(posedge clk) begin
        if (rst) begin
            x_valid_q   <= 1'b0;
            x_op_q      <= '0;
            x_a_q       <= '0;
            x_b_q       <= '0;
            x_rd_q      <= '0;
            x_we_q      <= 1'b0;
`ifdef ALU_MUL_EN
            mul_cnt_q   <= '0;
            x_acc_q     <= '0;
`endif
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_rd_q    <= '0;
            res_zero_q  <= 1'b1;
        end else begin
            x_valid_q   <= x_valid_d;
            x_op_q      <= x_op_d;
            x_a_q       <= x_a_d;
            x_b_q       <= x_b_d;
            x_rd_q      <= x_rd_d;
            x_we_q      <= x_we_d;
`ifdef ALU_MUL_EN
            mul_cnt_q   <= mul_cnt_d;
            x_acc_q     <= x_acc_d;
`endif
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_rd_q    <= res_rd_d;
            res_zero_q  <= res_zero_d;
        end
    end

    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_rd    = res_rd_q;
    assign bus.res_zero  = res_zero_q;
endmodule

// File: tb/tb_regfile_alu_pipe.sv
// Bench for regfile_alu_pipe (WIDTH=32, NREGS=32): table-driven ALU vectors,
// hand-written pipeline corner sequences, scoreboard queue of retired results.
module tb_regfile_alu_pipe;
    localparam int WIDTH = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             dbg_we;
    logic [AW-1:0]    dbg_addr;
    logic [WIDTH-1:0] dbg_wdata;
    logic [AW-1:0]    probe_addr;
    logic [WIDTH-1:0] probe_data;

    regfile_alu_pipe_if #(.WIDTH(WIDTH), .NREGS(NREGS)) bus ();

    regfile_alu_pipe #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .dbg_we     (dbg_we),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .probe_addr (probe_addr),
        .probe_data (probe_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] exp;
    } vec_t;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic [AW-1:0]    rd;
    } exp_t;

    vec_t vecs [13];
    exp_t sb [$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Scoreboard: every retirement is compared with the oldest expectation
    always @(negedge clk) begin
        if (!rst && bus.res_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_retire actual=rd%0d/%h required=no_retire", bus.res_rd, bus.res_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("retire rd=%0d data=%h zero=%0b", bus.res_rd, bus.res_data, bus.res_zero);
                check("res_data", bus.res_data, e.data);
                check("res_rd", WIDTH'(bus.res_rd), WIDTH'(e.rd));
                check("res_zero", WIDTH'(bus.res_zero), WIDTH'(e.data == '0));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dbg_write(input logic [AW-1:0] addr, input logic [WIDTH-1:0] data);
        dbg_we    = 1'b1;
        dbg_addr  = addr;
        dbg_wdata = data;
        tick();
        dbg_we    = 1'b0;
    endtask

    task automatic probe(input string name, input logic [AW-1:0] addr, input logic [WIDTH-1:0] req);
        probe_addr = addr;
        #1;
        check(name, probe_data, req);
    endtask

    // Drive one op, wait (bounded) for in_ready, log it at the accepting edge
    task automatic issue(input logic [2:0] op, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                         input logic [AW-1:0] rd, input logic we, input logic [WIDTH-1:0] exp,
                         input bit push);
        int n;
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_rs1   = rs1;
        bus.in_rs2   = rs2;
        bus.in_rd    = rd;
        bus.in_we    = we;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            tick();
            n++;
        end
        if (!bus.in_ready) begin
            checks++;
            failures++;
            $display("FAIL issue_timeout actual=in_ready_low required=in_ready_high");
        end
        $display("issue op=%b rd=%0d rs1=%0d rs2=%0d we=%0b", op, rd, rs1, rs2, we);
        if (push) sb.push_back('{data: exp, rd: rd});
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d_pending required=0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{3'b010, 32'd5,          32'd7,          32'd12};
        vecs[1]  = '{3'b010, 32'hFFFF_FFFF,  32'd2,          32'd1};
        vecs[2]  = '{3'b110, 32'd12,         32'd5,          32'd7};
        vecs[3]  = '{3'b110, 32'd5,          32'd7,          32'hFFFF_FFFE};
        vecs[4]  = '{3'b110, 32'd7,          32'd7,          32'd0};
        vecs[5]  = '{3'b000, 32'hF0F0_1234,  32'h0FF0_FF00,  32'h00F0_1200};
        vecs[6]  = '{3'b001, 32'hF000_0001,  32'h0000_1230,  32'hF000_1231};
        vecs[7]  = '{3'b111, 32'hFFFF_FFFF,  32'd1,          32'd1};
        vecs[8]  = '{3'b111, 32'd1,          32'hFFFF_FFFF,  32'd0};
        vecs[9]  = '{3'b111, 32'h8000_0000,  32'h7FFF_FFFF,  32'd1};
        vecs[10] = '{3'b111, 32'd5,          32'd5,          32'd0};
        vecs[11] = '{3'b100, 32'd5,          32'd7,          32'd0};
        vecs[12] = '{3'b101, 32'd5,          32'd7,          32'd0};

        rst          = 1'b1;
        dbg_we       = 1'b0;
        dbg_addr     = '0;
        dbg_wdata    = '0;
        probe_addr   = '0;
        bus.in_valid = 1'b0;
        bus.in_op    = '0;
        bus.in_rs1   = '0;
        bus.in_rs2   = '0;
        bus.in_rd    = '0;
        bus.in_we    = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        check("rst_in_ready", WIDTH'(bus.in_ready), 32'd1);
        check("rst_res_valid", WIDTH'(bus.res_valid), 32'd0);
        check("rst_res_data", bus.res_data, 32'd0);
        check("rst_res_rd", WIDTH'(bus.res_rd), 32'd0);
        check("rst_res_zero", WIDTH'(bus.res_zero), 32'd1);
        for (int i = 0; i < NREGS; i++) probe("rst_probe", AW'(i), 32'd0);

        // ALU vectors: r1=a, r2=b, r3 = a op b
        for (int i = 0; i < 13; i++) begin
            dbg_write(5'd1, vecs[i].a);
            dbg_write(5'd2, vecs[i].b);
            issue(vecs[i].op, 5'd1, 5'd2, 5'd3, 1'b1, vecs[i].exp, 1'b1);
            drain();
            probe("vec_probe_r3", 5'd3, vecs[i].exp);
        end

        // Back-to-back dependent ops through the bypass
        dbg_write(5'd1, 32'd5);
        dbg_write(5'd2, 32'd7);
        issue(3'b010, 5'd1, 5'd2, 5'd3, 1'b1, 32'd12, 1'b1);
        check("b2b_in_ready", WIDTH'(bus.in_ready), 32'd1);
        issue(3'b110, 5'd3, 5'd1, 5'd4, 1'b1, 32'd7, 1'b1);
        issue(3'b010, 5'd4, 5'd4, 5'd5, 1'b1, 32'd14, 1'b1);
        drain();
        probe("b2b_probe_r4", 5'd4, 32'd7);
        probe("b2b_probe_r5", 5'd5, 32'd14);

        // Writes to r0 are dropped from both ports
        issue(3'b010, 5'd1, 5'd2, 5'd0, 1'b1, 32'd12, 1'b1);
        drain();
        probe("r0_after_alu", 5'd0, 32'd0);
        dbg_write(5'd0, 32'h55);
        probe("r0_after_dbg", 5'd0, 32'd0);

        // Same-edge conflict: pipeline r6=0x55 beats debug r6=0xAA
        dbg_write(5'd1, 32'h55);
        dbg_write(5'd2, 32'h0);
        issue(3'b010, 5'd1, 5'd2, 5'd6, 1'b1, 32'h55, 1'b1);
        dbg_write(5'd6, 32'hAA);
        drain();
        probe("conflict_r6", 5'd6, 32'h55);
        // Different addresses on the same edge both land
        issue(3'b010, 5'd1, 5'd2, 5'd8, 1'b1, 32'h55, 1'b1);
        dbg_write(5'd9, 32'h33);
        drain();
        probe("dual_r8", 5'd8, 32'h55);
        probe("dual_r9", 5'd9, 32'h33);

        // we=0: result retires but nothing is written
        issue(3'b010, 5'd1, 5'd2, 5'd13, 1'b0, 32'h55, 1'b1);
        drain();
        probe("nowe_r13", 5'd13, 32'd0);

`ifdef ALU_MUL_EN
        begin
            int low;
            dbg_write(5'd1, 32'd6);
            dbg_write(5'd2, 32'd7);
            issue(3'b011, 5'd1, 5'd2, 5'd10, 1'b1, 32'd42, 1'b1);
            low = 0;
            while (!bus.in_ready && low < 100) begin
                low++;
                tick();
            end
            check("mul_ready_low_cycles", WIDTH'(low), 32'd31);
            tick();
            check("mul_res_valid_n32", WIDTH'(bus.res_valid), 32'd1);
            drain();
            probe("mul_probe_r10", 5'd10, 32'd42);

            dbg_write(5'd1, 32'hFFFF_FFFF);
            dbg_write(5'd2, 32'd3);
            issue(3'b011, 5'd1, 5'd2, 5'd11, 1'b1, 32'hFFFF_FFFD, 1'b1);
            drain();

            // Reset mid-multiply: nothing retires, destination untouched
            dbg_write(5'd1, 32'd6);
            dbg_write(5'd2, 32'd7);
            issue(3'b011, 5'd1, 5'd2, 5'd14, 1'b1, 32'd0, 1'b0);
            repeat (10) tick();
            rst = 1'b1;
            tick();
            rst = 1'b0;
            check("mul_rst_in_ready", WIDTH'(bus.in_ready), 32'd1);
            repeat (40) tick();
            check("mul_rst_res_valid", WIDTH'(bus.res_valid), 32'd0);
            probe("mul_rst_r14", 5'd14, 32'd0);
        end
`else
        dbg_write(5'd1, 32'd6);
        dbg_write(5'd2, 32'd7);
        issue(3'b011, 5'd1, 5'd2, 5'd10, 1'b1, 32'd0, 1'b1);
        check("mul_off_in_ready", WIDTH'(bus.in_ready), 32'd1);
        drain();
        probe("mul_off_r10", 5'd10, 32'd0);
`endif

        // Reset on the retiring edge of a single-cycle op discards it
        dbg_write(5'd1, 32'd5);
        dbg_write(5'd2, 32'd7);
        issue(3'b010, 5'd1, 5'd2, 5'd12, 1'b1, 32'd0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_res_valid", WIDTH'(bus.res_valid), 32'd0);
        repeat (5) tick();
        probe("rst_mid_r12", 5'd12, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
